tuple_record_fifo: RTL and testbench
====================================

TUPLE_RECORD_FIFO -- requirements
Module: tuple_record_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of record entries (power of two, minimum 2).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port ASYNCRESETN, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port I_a_a__0_0, input, 2 bits: incoming record field a.a[0].
REQ-005 The block SHALL have port I_b, input, 1 bit: incoming record field b.
REQ-006 The block SHALL have port I_valid, input, 1 bit: the upstream record stage presents a record.
REQ-007 The block SHALL have port I_ready, output, 1 bit: the FIFO can accept a record this cycle.
REQ-008 The block SHALL have port O_a_a__0_0, output, 2 bits: head record field a.a[0].
REQ-009 The block SHALL have port O_b, output, 1 bit: head record field b.
REQ-010 The block SHALL have port O_valid, output, 1 bit: a head record is available.
REQ-011 The block SHALL have port O_ready, input, 1 bit: the downstream consumer takes the head record.
REQ-012 The block SHALL have port clr, input, 1 bit: synchronous flush.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 A push SHALL occur on a cycle with I_valid=1, I_ready=1 and clr=0; a pop SHALL occur on a cycle with O_valid=1, O_ready=1 and clr=0.
REQ-015 Each record SHALL be stored packed as 3 bits {b, a.a[0][1:0]}, with b at bit 2.
REQ-016 I_ready SHALL equal (count < DEPTH); it SHALL be combinational from state only, never from I_valid or O_ready.
REQ-017 O_valid SHALL equal (count != 0); O_a_a__0_0 and O_b SHALL show the head entry whenever O_valid=1.
REQ-018 The outputs O_a_a__0_0 and O_b SHALL be 0 whenever O_valid=0.
REQ-019 There SHALL be no bypass: a record pushed at edge N becomes visible at O_* after edge N at the earliest, giving one cycle of latency.
REQ-020 The write and read pointers SHALL be clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH without a gap.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance; this SHALL be legal at any non-empty, non-full occupancy.
REQ-022 When full, I_ready SHALL be 0, so no push occurs even if a pop happens in the same cycle; I_ready SHALL rise in the cycle after the pop.
REQ-023 When empty, O_valid SHALL be 0, so O_ready is ignored and the pointers are unchanged.
REQ-024 On clr=1, the next edge SHALL set count to 0 and both pointers to 0; clr SHALL win over any push or pop in the same cycle, and that push SHALL be dropped.
REQ-025 The first-in record SHALL be the first out, with the fields unmodified.

Reset
REQ-026 Asserting ASYNCRESETN=0 SHALL immediately force count=0, both pointers to 0, O_valid=0, O_a_a__0_0=0, O_b=0 and I_ready=1, regardless of CLK.
REQ-027 A reset asserted mid-stream SHALL discard all stored records; the storage array needs no reset because REQ-018 masks the outputs.
REQ-028 Deassertion of reset SHALL be synchronous to CLK; no push SHALL be accepted on the deasserting edge.

Structure
REQ-029 A shared package SHALL hold the record typedef (a: 1-element array of 2-bit, b: 1-bit), the constant RECORD_W=3, and the pack and unpack functions.
REQ-030 DEPTH-derived widths SHALL be localparams inside the module.
REQ-031 One sub-module, tuple_record_mem, SHALL hold the DEPTH x 3 storage, with one registered write port and one combinational read port.

Verification
REQ-032 Reset then idle: count=0, O_valid=0, I_ready=1 and O_*=0 SHALL hold for 10 cycles.
REQ-033 Push {a=2'b10,b=1} at cycle 0 -> O_valid=1 at cycle 1 with O_a_a__0_0=2'b10 and O_b=1; pop -> count returns to 0.
REQ-034 Push 4 records with DEPTH=4 -> count=4 and I_ready=0; a fifth push with I_valid=1 is ignored; the 4 records SHALL pop in order.
REQ-035 Hold count=2 and push and pop together for 8 cycles, so the pointers wrap twice -> count stays at 2 and the output order matches the input order.
REQ-036 With count=3, assert clr together with I_valid=1 -> next cycle count=0, O_valid=0, and the pushed record never appears.
REQ-037 With count=3, pull ASYNCRESETN low between clock edges -> O_valid=0 and count=0 without waiting for a clock edge, and the FIFO is empty after release.

Source files
------------

// File: rtl/tuple_record_fifo_pkg.sv
// Shared record definitions for the tuple record FIFO.
// Holds the record typedef, the packed storage width and the
// pack/unpack helpers. In storage, b sits at bit 2 and a.a[0] sits at bits 1:0.
package tuple_record_fifo_pkg;

   localparam int RECORD_W = 3;

   typedef struct packed {
      logic [0:0][1:0] a;
   } rec_a_t;

   typedef struct packed {
      rec_a_t a;
      logic   b;
   } rec_t;

   function automatic logic [RECORD_W-1:0] pack_rec(input rec_t r);
      return {r.b, r.a.a[0]};
   endfunction

   function automatic rec_t unpack_rec(input logic [RECORD_W-1:0] w);
      rec_t r;
      r.a.a[0] = w[1:0];
      r.b      = w[2];
      return r;
   endfunction

endpackage

// File: rtl/tuple_record_mem.sv
// Record storage for tuple_record_fifo: DEPTH x RECORD_W bits.
// Ports:
//   clk   - write clock
//   we    - write enable; waddr/wdata are captured on the rising edge
//   raddr - read address; rdata is combinational from the array
// The storage has no reset. The parent masks the outputs while the FIFO is empty.
module tuple_record_mem
   import tuple_record_fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [RECORD_W-1:0] wdata,
   input  logic [AW-1:0]       raddr,
   output logic [RECORD_W-1:0] rdata
);

   logic [RECORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/tuple_record_fifo.sv
// tuple_record_fifo: DEPTH-entry FIFO of {a.a[0][1:0], b} records.
// Ports:
//   CLK, ASYNCRESETN      - clock and asynchronous active-low reset
//   I_a_a__0_0, I_b       - incoming record fields
//   I_valid / I_ready     - upstream handshake (I_ready depends only on state)
//   O_a_a__0_0, O_b       - head record fields (0 while the FIFO is empty)
//   O_valid / O_ready     - downstream handshake
//   clr                   - synchronous flush; it takes priority over push and pop
//   count                 - current occupancy
// There is no bypass path. A pushed record appears at the outputs one cycle later.
module tuple_record_fifo
   import tuple_record_fifo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     ASYNCRESETN,
   input  logic [1:0]               I_a_a__0_0,
   input  logic                     I_b,
   input  logic                     I_valid,
   output logic                     I_ready,
   output logic [1:0]               O_a_a__0_0,
   output logic                     O_b,
   output logic                     O_valid,
   input  logic                     O_ready,
   input  logic                     clr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [RECORD_W-1:0] wdata, rdata;
   rec_t          in_rec, head_rec;

   assign I_ready = (count_q < CW'(DEPTH));
   assign O_valid = (count_q != '0);
   assign count   = count_q;

   // A flush cancels any handshake in the same cycle.
   assign push = I_valid & I_ready & ~clr;
   assign pop  = O_valid & O_ready & ~clr;

   always_comb begin
      in_rec        = '0;
      in_rec.a.a[0] = I_a_a__0_0;
      in_rec.b      = I_b;
      wdata         = pack_rec(in_rec);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   tuple_record_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (CLK),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   // Storage has no reset, so the outputs must be masked while the FIFO is empty.
   always_comb begin
      head_rec   = unpack_rec(rdata);
      O_a_a__0_0 = O_valid ? head_rec.a.a[0] : 2'b00;
      O_b        = O_valid ? head_rec.b      : 1'b0;
   end

endmodule

// File: tb/tb_tuple_record_fifo.sv
// Directed self-checking bench for tuple_record_fifo (DEPTH=4).
module tb_tuple_record_fifo;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          CLK = 1'b0;
   logic          ASYNCRESETN;
   logic [1:0]    I_a_a__0_0;
   logic          I_b;
   logic          I_valid;
   logic          I_ready;
   logic [1:0]    O_a_a__0_0;
   logic          O_b;
   logic          O_valid;
   logic          O_ready;
   logic          clr;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   logic [2:0] q_rec [$];   // {b, a}
   logic [2:0] exp_rec;

   tuple_record_fifo #(.DEPTH(DEPTH)) dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .I_a_a__0_0  (I_a_a__0_0),
      .I_b         (I_b),
      .I_valid     (I_valid),
      .I_ready     (I_ready),
      .O_a_a__0_0  (O_a_a__0_0),
      .O_b         (O_b),
      .O_valid     (O_valid),
      .O_ready     (O_ready),
      .clr         (clr),
      .count       (count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_count"}, 8'(count), 8'd0);
      chk({tag, "_ovalid"}, 8'(O_valid), 8'd1 - 8'd1);
      chk({tag, "_iready"}, 8'(I_ready), 8'd1);
      chk({tag, "_odata"}, 8'({O_b, O_a_a__0_0}), 8'd0);
   endtask

   task automatic chk_head(input string tag, input logic [2:0] r);
      chk({tag, "_ovalid"}, 8'(O_valid), 8'd1);
      chk({tag, "_oa"}, 8'(O_a_a__0_0), 8'(r[1:0]));
      chk({tag, "_ob"}, 8'(O_b), 8'(r[2]));
   endtask

   initial begin
      ASYNCRESETN = 1'b0;
      I_a_a__0_0 = 2'b00; I_b = 1'b0; I_valid = 1'b0; O_ready = 1'b0; clr = 1'b0;
      #12;
      chk_empty("reset");
      @(negedge CLK); ASYNCRESETN = 1'b1;

      // Reset, then idle for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_empty("idle");
      end

      // Push a single record. It must not bypass to the output in the same cycle.
      I_a_a__0_0 = 2'b10; I_b = 1'b1; I_valid = 1'b1;
      #1;
      chk("nobypass_ovalid", 8'(O_valid), 8'd0);
      tick();
      I_valid = 1'b0;
      chk_head("single", 3'b110);
      chk("single_count", 8'(count), 8'd1);
      O_ready = 1'b1;
      tick();
      O_ready = 1'b0;
      chk_empty("single_pop");

      // Fill the FIFO with four records.
      for (int i = 0; i < 4; i++) begin
         I_a_a__0_0 = 2'(i); I_b = i[0]; I_valid = 1'b1;
         q_rec.push_back({i[0], 2'(i)});
         tick();
      end
      chk("full_count", 8'(count), 8'd4);
      chk("full_iready", 8'(I_ready), 8'd0);
      // A fifth push while full is ignored.
      I_a_a__0_0 = 2'b11; I_b = 1'b1; I_valid = 1'b1;
      tick();
      chk("full_ignore_count", 8'(count), 8'd4);
      // Pop while full with I_valid still high: no push, so I_ready rises the next cycle.
      O_ready = 1'b1;
      exp_rec = q_rec.pop_front();
      chk_head("full_pop", exp_rec);
      tick();
      I_valid = 1'b0;
      chk("full_pop_count", 8'(count), 8'd3);
      chk("full_pop_iready", 8'(I_ready), 8'd1);
      for (int i = 0; i < 3; i++) begin
         exp_rec = q_rec.pop_front();
         chk_head("drain", exp_rec);
         tick();
      end
      O_ready = 1'b0;
      chk_empty("drained");

      // Hold count at 2 while pushing and popping together for 8 cycles.
      I_valid = 1'b1;
      I_a_a__0_0 = 2'b01; I_b = 1'b0; q_rec.push_back(3'b001); tick();
      I_a_a__0_0 = 2'b10; I_b = 1'b1; q_rec.push_back(3'b110); tick();
      chk("steady_count0", 8'(count), 8'd2);
      O_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         I_a_a__0_0 = 2'(k + 3); I_b = k[0];
         exp_rec = q_rec.pop_front();
         q_rec.push_back({k[0], 2'(k + 3)});
         chk_head("steady", exp_rec);
         tick();
         chk("steady_count", 8'(count), 8'd2);
      end
      I_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_rec = q_rec.pop_front();
         chk_head("steady_drain", exp_rec);
         tick();
      end
      O_ready = 1'b0;
      chk_empty("steady_done");

      // At count 3, clr with I_valid: flush wins and the pushed record is dropped.
      I_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         I_a_a__0_0 = 2'(i + 1); I_b = 1'b0; tick();
      end
      chk("clr_pre_count", 8'(count), 8'd3);
      clr = 1'b1; I_a_a__0_0 = 2'b11; I_b = 1'b1;
      tick();
      clr = 1'b0; I_valid = 1'b0;
      chk_empty("clr");
      tick();
      chk_empty("clr_after");

      // At count 3, assert reset asynchronously between clock edges.
      I_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         I_a_a__0_0 = 2'(i); I_b = 1'b1; tick();
      end
      I_valid = 1'b0;
      chk("arst_pre_count", 8'(count), 8'd3);
      #2;
      ASYNCRESETN = 1'b0;
      #1;
      chk_empty("arst");
      @(negedge CLK); ASYNCRESETN = 1'b1;
      tick();
      chk_empty("arst_release");

      // Traffic after reset release still works.
      I_a_a__0_0 = 2'b01; I_b = 1'b1; I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      chk_head("post_rst", 3'b101);
      O_ready = 1'b1;
      tick();
      O_ready = 1'b0;
      chk_empty("post_rst_pop");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
